// File: rtl/dm_responder_pkg.sv
// Shared constants for the data-memory responder: wait-state counter width,
// FSM state encodings and a byte-lane mask helper.
package dm_responder_pkg;

  localparam int DM_LAT_W = 4;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_t;

  // Expands a 4-bit byte enable into a 32-bit mask, one byte per enable bit.
  function automatic logic [31:0] dm_lane_mask(input logic [3:0] byteen);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{byteen[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational store merge: enabled lanes take wdata, the remaining lanes
// keep the old word.
module dm_byte_merge
  import dm_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] merged_word
);

  logic [31:0] lane_mask;

  assign lane_mask   = dm_lane_mask(byteen);
  assign merged_word = (old_word & ~lane_mask) | (wdata & lane_mask);

endmodule

// File: rtl/dm_responder.sv
// Memory-side target for M-stage data requests: one request at a time,
// LATENCY wait states, byte-enable stores, held response until taken.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          DEPTH   = 3072,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmr_state_t          state, state_next;
  logic [DM_LAT_W-1:0] cnt;
  logic                access;

  logic                l_we;
  logic [31:0]         l_addr;
  logic [3:0]          l_byteen;
  logic [31:0]         l_wdata;
  logic [31:0]         l_pc;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         word_off;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [31:0]         old_word;
  logic [31:0]         merged_word;

  // BASE is word-aligned, so the low address bits never borrow into the index;
  // addresses below BASE wrap to a huge offset and fall out of range.
  assign word_off = (l_addr - BASE) >> 2;
  assign in_range = (word_off < 32'(DEPTH));
  assign idx      = word_off[IDX_W-1:0];
  assign old_word = in_range ? mem[idx] : '0;

  dm_byte_merge u_merge (
    .old_word    (old_word),
    .wdata       (l_wdata),
    .byteen      (l_byteen),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DMR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    access     = 1'b0;
    case (state)
      DMR_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = DMR_WAIT;
        end
      end
      DMR_WAIT: begin
        if (cnt == '0) begin
          access     = 1'b1;
          state_next = DMR_RESP;
        end
      end
      DMR_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = DMR_IDLE;
        end
      end
      default: state_next = DMR_IDLE;
    endcase
  end

  // Request latch, wait counter and response registers; the response stays
  // put until the next access so rdata/err are stable under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_byteen   <= '0;
      l_wdata    <= '0;
      l_pc       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (state == DMR_IDLE && req_valid) begin
        l_we     <= req_we;
        l_addr   <= req_addr;
        l_byteen <= req_byteen;
        l_wdata  <= req_wdata;
        l_pc     <= req_pc;
        cnt      <= DM_LAT_W'(LATENCY);
      end else if (state == DMR_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        resp_err   <= !in_range;
        resp_rdata <= (in_range && !l_we) ? old_word : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (access && l_we && in_range) begin
      mem[idx] <= merged_word;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && access && l_we && in_range && (l_byteen != 4'b0000)) begin
      $display("%d@%h: *%h <= %h", $time, l_pc, {l_addr[31:2], 2'b00}, merged_word);
    end
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: a word-array reference model predicts
// each response at accept time; an independent monitor checks what comes out.
module tb_dm_responder;

  localparam int          DEPTH   = 3072;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_byteen (req_byteen),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          accept_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          last_accept = 0;
  bit          seen_valid = 0;
  bit          rand_ready = 0;
  bit          fixed_ready = 1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    resp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endfunction

  // Reference behaviour: word index from the address, range check, byte-wise write.
  function automatic exp_t model_access(input logic we, input logic [31:0] addr,
                                        input logic [3:0] byteen, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] w;
    w = {2'b00, addr[31:2]} - {2'b00, BASE[31:2]};
    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.accept_cyc = 0;
    if (w >= DEPTH) begin
      e.err = 1'b1;
    end else if (we) begin
      for (int lane = 0; lane < 4; lane++)
        if (byteen[lane]) model_mem[w][8*lane +: 8] = wdata[8*lane +: 8];
    end else begin
      e.rdata = model_mem[w];
    end
    return e;
  endfunction

  // Called at a negedge; returns at a negedge after the request was accepted.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] byteen,
                               input logic [31:0] wdata, input logic [31:0] pc, output int waited);
    exp_t e;
    req_we     = we;
    req_addr   = addr;
    req_byteen = byteen;
    req_wdata  = wdata;
    req_pc     = pc;
    req_valid  = 1'b1;
    waited     = 0;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("req_accept_timeout", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    e = model_access(we, addr, byteen, wdata);
    e.accept_cyc = cyc + 1;
    last_accept  = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = $urandom_range(0, 1) == 1;
    req_addr   = $urandom;
    req_byteen = 4'($urandom);
    req_wdata  = $urandom;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: checks latency on first valid, data on every valid cycle, pops on handshake.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      checkOutput("req_ready_while_resp", {31'b0, req_ready}, 32'h0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp_valid", {31'b0, resp_valid}, 32'h0);
      end else begin
        if (!seen_valid) begin
          checkOutput("latency", cyc, exp_q[0].accept_cyc + LATENCY + 1);
          seen_valid = 1;
        end
        checkOutput("resp_rdata", resp_rdata, exp_q[0].rdata);
        checkOutput("resp_err", {31'b0, resp_err}, {31'b0, exp_q[0].err});
        if (resp_ready) begin
          void'(exp_q.pop_front());
          seen_valid = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, a1, a2, n;
    logic [31:0] addr;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_byteen = '0;
    req_wdata = '0; req_pc = '0; resp_ready = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("idle_resp_rdata", resp_rdata, 32'h0);
    checkOutput("idle_resp_err", {31'b0, resp_err}, 32'h0);

    $display("[TB] directed: store/load/merge/range");
    applyStimulus(1'b0, 32'h0000_0000, 4'h0, 32'h0, 32'h1000, w);
    applyStimulus(1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h3000, w);
    applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h3004, w);
    applyStimulus(1'b1, 32'h0000_0012, 4'b0010, 32'h0000_AB00, 32'h3008, w);
    applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h300C, w);
    applyStimulus(1'b1, 32'h0000_0014, 4'h0, 32'hDEAD_BEEF, 32'h3010, w);
    applyStimulus(1'b0, 32'h0000_0014, 4'h0, 32'h0, 32'h3014, w);
    applyStimulus(1'b1, 32'h0000_2FFC, 4'hF, 32'hCAFE_F00D, 32'h3018, w);
    applyStimulus(1'b0, 32'h0000_3000, 4'h0, 32'h0, 32'h301C, w);
    applyStimulus(1'b1, 32'h0000_3000, 4'hF, 32'h5555_AAAA, 32'h3020, w);
    applyStimulus(1'b0, 32'h0000_2FFC, 4'h0, 32'h0, 32'h3024, w);
    applyStimulus(1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 32'h3028, w);

    $display("[TB] directed: spacing with resp_ready held high");
    drain();
    applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h4000, w);
    a1 = last_accept;
    applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h4004, w);
    a2 = last_accept;
    checkOutput("accept_spacing", a2 - a1, LATENCY + 3);

    $display("[TB] directed: backpressure and handshake-cycle request");
    drain();
    fixed_ready = 0;
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h5000, w);
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    checkOutput("resp_valid_seen", {31'b0, resp_valid}, 32'h1);
    repeat (5) @(negedge clk);
    fixed_ready = 1;
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_0018, 4'hF, 32'h0BAD_CAFE, 32'h5004, w);
    checkOutput("handshake_cycle_wait", w, 1);

    $display("[TB] directed: reset during wait states");
    drain();
    req_we = 1'b1; req_addr = 32'h0000_0020; req_byteen = 4'hF;
    req_wdata = 32'h7777_8888; req_pc = 32'h6000; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    clear_model();
    #1;
    checkOutput("midwait_reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("midwait_reset_req_ready", {31'b0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h6004, w);
    applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h6008, w);

    $display("[TB] random traffic");
    rand_ready = 1;
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0, 1:    addr = 32'($urandom_range(0, 255));
        2:       addr = 32'h0000_2FF0 + 32'($urandom_range(0, 31));
        default: addr = $urandom;
      endcase
      applyStimulus($urandom_range(0, 1) == 1, addr, 4'($urandom), $urandom, $urandom, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
